svp_row_ctrl: RTL
=================

# svp_row_ctrl

Row/frame sequencer for the stereo vision processor input path. Sits between the phase-map AXI-Stream source and the input-control stage, and passes beats through with zero latency. It counts beats per row and rows per frame, regenerates a correct tlast, and throttles on FIFO prog-full. A row-credit counter bounds how many rows are in flight in the matcher.

## Interface
Parameters:
- COLS, 1280, pixels per row
- ROWS, 1024, rows per frame
- BEAT_SIZE, 8, pixels per beat; COLS is a multiple of BEAT_SIZE; BPR = COLS/BEAT_SIZE
- MAX_INFLIGHT, 2, maximum rows accepted but not yet reported done (≥1)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- enable  in  1  allows a new frame to start; sampled only in IDLE
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tready  out  1  upstream ready
- s_axis_tlast  in  1  upstream end-of-row marker
- ds_tvalid  out  1  downstream beat valid; data bypasses this block
- ds_tready  in  1  downstream ready
- ds_tlast  out  1  regenerated end-of-row
- pfull  in  1  OR of downstream FIFO prog-full flags
- row_done  in  1  one-cycle pulse from the output side, one per finished row
- frame_start  out  1  one-cycle pulse on IDLE→STREAM
- frame_done  out  1  one-cycle pulse on DRAIN→IDLE
- col_idx  out  $clog2(BPR)  beat index within the current row
- row_idx  out  $clog2(ROWS)  current row index
- inflight  out  $clog2(MAX_INFLIGHT+1)  rows in flight
- err_early_last  out  1  sticky; tlast arrived before beat BPR-1
- err_late_last  out  1  sticky; tlast missing on beat BPR-1
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: when enable=1, go to STREAM, pulse frame_start, clear the sticky errors, and zero col_idx and row_idx.
  - STREAM: passes beats.
  - WAIT_CREDIT: row boundary reached with inflight == MAX_INFLIGHT. Go to STREAM when inflight < MAX_INFLIGHT.
  - DRAIN: the last row of the frame has been accepted. When inflight == 0, pulse frame_done and go to IDLE.
- Gating (combinational):
  - s_axis_tready = STREAM & ds_tready & !pfull
  - ds_tvalid = STREAM & s_axis_tvalid & !pfull
  - A beat is accepted when s_axis_tvalid & s_axis_tready.
- ds_tlast = (col_idx == BPR-1) | s_axis_tlast, gated by STREAM.
- Row end occurs on an accepted beat with ds_tlast=1:
  - col_idx←0 and inflight increments.
  - If row_idx == ROWS-1, go to DRAIN; otherwise row_idx increments.
  - If the post-increment inflight == MAX_INFLIGHT and the frame is not finished, go to WAIT_CREDIT; otherwise stay in STREAM.
- On an accepted beat that is not a row end, col_idx increments.
- Early tlast (s_axis_tlast=1 with col_idx < BPR-1): the row is truncated (treated as a row end) and err_early_last←1.
- Late tlast (col_idx == BPR-1 with s_axis_tlast=0): the row still ends and err_late_last←1.
- Credits:
  - A row_done pulse decrements inflight.
  - Row end and row_done in the same cycle leave inflight unchanged.
  - row_done with inflight=0 is ignored; the counter saturates at 0.
- Deasserting enable mid-frame has no effect; the frame completes. enable is next sampled in IDLE.

## Timing
- Reset values:
  - All outputs 0: s_axis_tready=0, ds_tvalid=0, ds_tlast=0.
  - col_idx=0, row_idx=0, inflight=0.
  - Both error flags 0; frame_start=0, frame_done=0; busy=0.
  - State IDLE.
- Reset mid-frame discards all counts and returns to IDLE on the next edge.
- Handshake path s_axis→ds has zero latency and no register. pfull removes ready and valid in the same cycle.
- frame_start is asserted in the cycle the state register becomes STREAM, so beats can be accepted that same cycle.
- Credit release: if row_done arrives in cycle N while in WAIT_CREDIT, the block is in STREAM and ready by cycle N+1.
- Timing of frame_done:
  - Asserted the cycle after inflight reaches 0 in DRAIN.
  - If the last row end and a final row_done bring inflight to 0 at the same time, frame_done is asserted the cycle after entering DRAIN.
- Back-to-back frames: with enable held at 1, there is at least one IDLE cycle between frame_done and the next frame_start.

## Test plan
Bench parameters: COLS=64, BEAT_SIZE=8 (BPR=8), ROWS=4, MAX_INFLIGHT=2.
- Nominal frame:
  - Stimulus: enable=1; 32 beats with tlast on every 8th beat; row_done returned 3 cycles after each row end.
  - Response: 4 ds_tlast, one frame_start, one frame_done, no errors, row_idx back to 0.
- Credit stall:
  - Stimulus: withhold row_done.
  - Response: after 16 beats the block is in WAIT_CREDIT and s_axis_tready=0. A row_done pulse restores ready next cycle, and inflight goes 2→1.
- Early last:
  - Stimulus: tlast on beat 5 of row 0.
  - Response: ds_tlast on beat 5, err_early_last=1, row_idx=1, col_idx=0.
- Late last:
  - Stimulus: no tlast on beat 7.
  - Response: ds_tlast=1 on beat 7 anyway, err_late_last=1.
  - Both errors clear on the next frame_start.
- pfull and simultaneous events:
  - Stimulus: pfull=1 for 5 cycles mid-row; separately, row end and row_done in the same cycle.
  - Response: ready and valid are 0 for exactly those 5 cycles with col_idx held. In the simultaneous case inflight is unchanged.
- Reset mid-frame:
  - Stimulus: rst at row 2, column 3.
  - Response: all outputs 0 the next cycle, state IDLE. A following frame runs nominally.

Source files
------------

// File: rtl/svp_row_ctrl.sv
// Row/frame sequencer for the phase-map input path: zero-latency beat gating,
// tlast regeneration, prog-full throttling and row-credit flow control.
module svp_row_ctrl #(
  parameter int COLS         = 1280,
  parameter int ROWS         = 1024,
  parameter int BEAT_SIZE    = 8,
  parameter int MAX_INFLIGHT = 2,
  localparam int BPR = COLS / BEAT_SIZE,
  localparam int CW  = (BPR > 1) ? $clog2(BPR) : 1,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int IW  = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic          ds_tvalid,
  input  logic          ds_tready,
  output logic          ds_tlast,
  input  logic          pfull,
  input  logic          row_done,
  output logic          frame_start,
  output logic          frame_done,
  output logic [CW-1:0] col_idx,
  output logic [RW-1:0] row_idx,
  output logic [IW-1:0] inflight,
  output logic          err_early_last,
  output logic          err_late_last,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STREAM      = 2'd1,
    WAIT_CREDIT = 2'd2,
    DRAIN       = 2'd3
  } state_t;

  state_t        state;
  logic          streaming;
  logic          col_last;
  logic          accept;
  logic          row_end;
  logic [IW-1:0] inflight_nxt;

  always_comb begin
    streaming     = (state == STREAM);
    s_axis_tready = streaming & ds_tready & ~pfull;
    ds_tvalid     = streaming & s_axis_tvalid & ~pfull;
    col_last      = (col_idx == CW'(BPR - 1));
    ds_tlast      = streaming & (col_last | s_axis_tlast);
    accept        = s_axis_tvalid & s_axis_tready;
    row_end       = accept & ds_tlast;
    // A row end and a row_done in the same cycle cancel; row_done alone saturates at 0.
    inflight_nxt  = inflight;
    if (row_end && !row_done)
      inflight_nxt = inflight + 1'b1;
    else if (!row_end && row_done && (inflight != '0))
      inflight_nxt = inflight - 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      col_idx        <= '0;
      row_idx        <= '0;
      inflight       <= '0;
      err_early_last <= 1'b0;
      err_late_last  <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      inflight    <= inflight_nxt;
      case (state)
        IDLE: begin
          // Holding off while frame_done is high guarantees an idle gap between frames.
          if (enable && !frame_done) begin
            state          <= STREAM;
            frame_start    <= 1'b1;
            err_early_last <= 1'b0;
            err_late_last  <= 1'b0;
            col_idx        <= '0;
            row_idx        <= '0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (row_end) begin
              col_idx <= '0;
              if (s_axis_tlast && !col_last) err_early_last <= 1'b1;
              if (col_last && !s_axis_tlast) err_late_last  <= 1'b1;
              if (row_idx == RW'(ROWS - 1)) begin
                row_idx <= '0;
                state   <= DRAIN;
              end else begin
                row_idx <= row_idx + 1'b1;
                if (inflight_nxt == IW'(MAX_INFLIGHT)) state <= WAIT_CREDIT;
              end
            end else begin
              col_idx <= col_idx + 1'b1;
            end
          end
        end
        WAIT_CREDIT: begin
          // Look at the next count so a credit returns ready on the following cycle.
          if (inflight_nxt < IW'(MAX_INFLIGHT)) state <= STREAM;
        end
        DRAIN: begin
          if (inflight == '0) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
